// File: rtl/draw_screen_stripes_if.sv
// Video timing bundle from the timing generator, and the same timing plus
// colour as passed between draw stages.
interface timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_screen_stripes.sv
// Start-screen background: animated vertical stripes in top/bottom bands and a
// white centre field. Scroll/blink state advances once per frame, during vblank.
module draw_screen_stripes #(
    parameter int unsigned H_ACTIVE     = 1024,
    parameter int unsigned V_ACTIVE     = 768,
    parameter int unsigned STRIPE_W     = 40,
    parameter int unsigned BAND_H       = 64,
    parameter int unsigned NUM_COLOURS  = 6,
    parameter int unsigned SCROLL_DIV   = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    timing_if.slave    in,
    vga_if.master      out,
    output logic       frame_tick
);

    localparam int unsigned PW = (STRIPE_W > 1) ? $clog2(STRIPE_W) : 1;
    localparam int unsigned CW = (NUM_COLOURS > 1) ? $clog2(NUM_COLOURS) : 1;
    localparam int unsigned DW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PIX_MAX   = PW'(STRIPE_W - 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(NUM_COLOURS - 1);
    localparam logic [DW-1:0] DIV_MAX   = DW'(SCROLL_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    localparam logic [10:0] H_END    = 11'(H_ACTIVE);
    localparam logic [10:0] BAND_TOP = 11'(BAND_H);
    localparam logic [10:0] BAND_BOT = 11'(V_ACTIVE - BAND_H);

    localparam logic [11:0] YELLOW_START = 12'hff0;
    localparam logic [11:0] RED_START    = 12'hf00;
    localparam logic [11:0] BLACK_START  = 12'h000;
    localparam logic [11:0] GREEN_START  = 12'h0f0;
    localparam logic [11:0] WHITE_START  = 12'hfff;
    localparam logic [11:0] BLUE_START   = 12'h00f;

    function automatic logic [11:0] palette(input logic [2:0] idx);
        logic [11:0] c;
        unique case (idx)
            3'd0, 3'd6: c = YELLOW_START;
            3'd1, 3'd7: c = RED_START;
            3'd2:       c = BLACK_START;
            3'd3:       c = GREEN_START;
            3'd4:       c = WHITE_START;
            3'd5:       c = BLUE_START;
        endcase
        return c;
    endfunction

    logic          vblnk_prev;
    logic          frame_evt;
    logic [1:0]    mode_q;
    logic [PW-1:0] pix_off_q, pix_off_d;
    logic [CW-1:0] col_off_q, col_off_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d, cur_pix;
    logic [CW-1:0] col_cnt_q, col_cnt_d, cur_col;
    logic [11:0]   rgb_nxt;

    assign frame_evt = in.vblnk & ~vblnk_prev;

    // Frame-rate state; the scroll step deliberately uses the pre-update mode_q.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        pix_off_d   = pix_off_q;
        col_off_d   = col_off_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        if (frame_evt) begin
            if (div_cnt_q == DIV_MAX) begin
                div_cnt_d = '0;
                if (mode_q == 2'd1) begin
                    if (pix_off_q == PIX_MAX) begin
                        pix_off_d = '0;
                        col_off_d = (col_off_q == COL_MAX) ? '0 : col_off_q + 1'b1;
                    end else begin
                        pix_off_d = pix_off_q + 1'b1;
                    end
                end else if (mode_q == 2'd2) begin
                    if (pix_off_q == '0) begin
                        pix_off_d = PIX_MAX;
                        col_off_d = (col_off_q == '0) ? COL_MAX : col_off_q - 1'b1;
                    end else begin
                        pix_off_d = pix_off_q - 1'b1;
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        if (mode_q != 2'd3) begin
            blink_on_d = 1'b0;
        end
    end

    // Per-pixel stripe tracking; hcount==0 reloads from the frame's scroll position.
    always_comb begin
        cur_pix = (in.hcount == '0) ? pix_off_q : pix_cnt_q;
        cur_col = (in.hcount == '0) ? col_off_q : col_cnt_q;
        if (cur_pix == PIX_MAX) begin
            pix_cnt_d = '0;
            col_cnt_d = (cur_col == COL_MAX) ? '0 : cur_col + 1'b1;
        end else begin
            pix_cnt_d = cur_pix + 1'b1;
            col_cnt_d = cur_col;
        end
    end

    always_comb begin
        rgb_nxt = palette(3'(cur_col));
        if (in.hblnk || in.vblnk || in.hcount >= H_END) begin
            rgb_nxt = BLACK_START;
        end else if (in.vcount >= BAND_TOP && in.vcount < BAND_BOT) begin
            rgb_nxt = WHITE_START;
        end else if (mode_q == 2'd3 && blink_on_q) begin
            rgb_nxt = WHITE_START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev  <= 1'b0;
            mode_q      <= 2'd0;
            pix_off_q   <= '0;
            col_off_q   <= '0;
            div_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            pix_cnt_q   <= '0;
            col_cnt_q   <= '0;
            frame_tick  <= 1'b0;
            out.hcount  <= '0;
            out.vcount  <= '0;
            out.hsync   <= 1'b0;
            out.vsync   <= 1'b0;
            out.hblnk   <= 1'b0;
            out.vblnk   <= 1'b0;
            out.rgb     <= '0;
        end else begin
            vblnk_prev  <= in.vblnk;
            if (frame_evt) begin
                mode_q <= mode;
            end
            pix_off_q   <= pix_off_d;
            col_off_q   <= col_off_d;
            div_cnt_q   <= div_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            pix_cnt_q   <= pix_cnt_d;
            col_cnt_q   <= col_cnt_d;
            frame_tick  <= frame_evt;
            out.hcount  <= in.hcount;
            out.vcount  <= in.vcount;
            out.hsync   <= in.hsync;
            out.vsync   <= in.vsync;
            out.hblnk   <= in.hblnk;
            out.vblnk   <= in.vblnk;
            out.rgb     <= rgb_nxt;
        end
    end

endmodule
